// File: rtl/clk_gate_ctrl.sv
// Clock-gate handshake controller: OFF -> WAKE -> ON -> IDLE -> OFF.
// Optional macro CLK_GATE_TEST_MODE_EN adds TEST_MODE forcing CLK_EN high.
module clk_gate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       BUSY,
`ifdef CLK_GATE_TEST_MODE_EN
  input  logic       TEST_MODE,
`endif
  output logic       CLK_EN,
  output logic       ACK,
  output logic [1:0] GATE_STATE
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_WAKE = 2'b01,
    S_ON   = 2'b10,
    S_IDLE = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             ack_q, ack_d;
  logic             active;

  assign active = REQ | BUSY;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ack_d   = ack_q;
    unique case (state_q)
      S_OFF: begin
        if (REQ) begin
          state_d = S_WAKE;
          cnt_d   = CNT_ZERO;
          en_d    = 1'b1;
          ack_d   = 1'b0;
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = S_ON;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ON: begin
        if (!active) begin
          if (IDLE_CYCLES == 0) begin
            state_d = S_OFF;
            en_d    = 1'b0;
            ack_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = IDLE_LOAD;
          end
        end
      end
      S_IDLE: begin
        if (active) begin
          state_d = S_ON;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_OFF;
          en_d    = 1'b0;
          ack_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = CNT_ZERO;
        en_d    = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= CNT_ZERO;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

`ifdef CLK_GATE_TEST_MODE_EN
  assign CLK_EN = en_q | TEST_MODE;
`else
  assign CLK_EN = en_q;
`endif
  assign ACK        = ack_q;
  assign GATE_STATE = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: default instance plus
// an IDLE_CYCLES=0 instance; test-mode check under CLK_GATE_TEST_MODE_EN.
module tb_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       busy = 1'b0;
  logic       tm = 1'b0;
  logic       en0, ack0, en1, ack1;
  logic [1:0] st0, st1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    bit         d;
    logic       en;
    logic       ack;
    logic [1:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  clk_gate_ctrl u_dut0 (
    .CLK(clk), .RST(rst), .REQ(req), .BUSY(busy),
`ifdef CLK_GATE_TEST_MODE_EN
    .TEST_MODE(tm),
`endif
    .CLK_EN(en0), .ACK(ack0), .GATE_STATE(st0)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(0)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ(req), .BUSY(busy),
`ifdef CLK_GATE_TEST_MODE_EN
    .TEST_MODE(1'b0),
`endif
    .CLK_EN(en1), .ACK(ack1), .GATE_STATE(st1)
  );

  // Monitor: after each rising edge pop and compare due items
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic       a_en, a_ack;
        logic [1:0] a_st;
        e = q.pop_front();
        a_en  = e.d ? en1  : en0;
        a_ack = e.d ? ack1 : ack0;
        a_st  = e.d ? st1  : st0;
        checks++;
        if (a_en !== e.en || a_ack !== e.ack || a_st !== e.st) begin
          errors++;
          $display("FAIL %s cyc=%0d got en=%b ack=%b st=%b exp en=%b ack=%b st=%b",
                   e.nm, cyc, a_en, a_ack, a_st, e.en, e.ack, e.st);
        end
      end
    end
  end

  task automatic tick(input logic r, input logic b, input logic rs);
    @(negedge clk);
    req  = r;
    busy = b;
    rst  = rs;
  endtask

  task automatic expect_o(input bit d, input logic e, input logic a,
                          input logic [1:0] s, input string nm);
    exp_t x;
    x.cyc = cyc + 1;
    x.d   = d;
    x.en  = e;
    x.ack = a;
    x.st  = s;
    x.nm  = nm;
    q.push_back(x);
  endtask

  initial begin
    // reset
    tick(0, 0, 1);
    expect_o(0, 0, 0, 2'b00, "reset_d0");
    expect_o(1, 0, 0, 2'b00, "reset_d1");
    // BUSY alone does not wake
    tick(0, 1, 0);
    expect_o(0, 0, 0, 2'b00, "busy_no_wake");
    // wake sequence
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "wake_en");
    tick(0, 0, 0);
    expect_o(0, 1, 0, 2'b01, "wake_hold_noreq");
    tick(1, 0, 0);
    expect_o(0, 1, 1, 2'b10, "wake_ack");
    tick(1, 0, 0);
    expect_o(0, 1, 1, 2'b10, "on_hold");
    // idle expiry: 8 idle cycles then off
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      expect_o(0, 1, 1, 2'b11, $sformatf("idle_%0d", i));
    end
    tick(0, 0, 0);
    expect_o(0, 0, 0, 2'b00, "idle_expire");
    tick(0, 0, 0);
    expect_o(0, 0, 0, 2'b00, "off_stay");
`ifdef CLK_GATE_TEST_MODE_EN
    // test mode forces CLK_EN combinationally
    @(negedge clk);
    tm = 1'b1;
    #1;
    checks++;
    if (en0 !== 1'b1 || ack0 !== 1'b0 || st0 !== 2'b00) begin
      errors++;
      $display("FAIL test_mode_comb got en=%b ack=%b st=%b exp en=1 ack=0 st=00",
               en0, ack0, st0);
    end
    tick(0, 0, 0);
    expect_o(0, 1, 0, 2'b00, "test_mode_reg");
    tick(0, 0, 0);
    tm = 1'b0;
    expect_o(0, 0, 0, 2'b00, "test_mode_off");
`endif
    // wake again, then re-activation from IDLE at counter 3
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "wake2_en");
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "wake2_hold");
    tick(1, 0, 0);
    expect_o(0, 1, 1, 2'b10, "wake2_ack");
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      expect_o(0, 1, 1, 2'b11, $sformatf("idle2_%0d", i));
    end
    tick(0, 1, 0);
    expect_o(0, 1, 1, 2'b10, "reactivate");
    // idle counter reloads fully after re-activation
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      expect_o(0, 1, 1, 2'b11, $sformatf("idle3_%0d", i));
    end
    tick(0, 0, 0);
    expect_o(0, 0, 0, 2'b00, "idle3_expire");
    // reset mid-wake, then a complete wake
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "wake4_en");
    tick(1, 0, 1);
    expect_o(0, 0, 0, 2'b00, "rst_midwake");
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "rewake_en");
    tick(1, 0, 0);
    expect_o(0, 1, 0, 2'b01, "rewake_hold");
    tick(1, 0, 0);
    expect_o(0, 1, 1, 2'b10, "rewake_ack");
    // zero-idle instance
    tick(0, 0, 1);
    expect_o(1, 0, 0, 2'b00, "z_reset");
    tick(1, 0, 0);
    expect_o(1, 1, 0, 2'b01, "z_wake_en");
    tick(1, 0, 0);
    expect_o(1, 1, 0, 2'b01, "z_wake_hold");
    tick(1, 0, 0);
    expect_o(1, 1, 1, 2'b10, "z_ack");
    tick(0, 0, 0);
    expect_o(1, 0, 0, 2'b00, "z_direct_off");
    tick(0, 0, 0);
    expect_o(1, 0, 0, 2'b00, "z_off_stay");
    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
